// File: rtl/mc_maindec_if.sv
// Control bundle between the multicycle main decoder and its datapath.
// master = decoder side (drives controls), slave = datapath side (drives opcode and zero flag).
interface mc_maindec_if;
  logic [5:0] op;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       iord;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic [3:0] state_o;

  modport master (
    input  op, zero,
    output pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, aluop, state_o
  );

  modport slave (
    output op, zero,
    input  pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, aluop, state_o
  );
endinterface

// File: rtl/mc_maindec.sv
// Multicycle MIPS main decoder: Moore FSM, 2-5 cycles per instruction, no backpressure (op held by datapath).
// MC_MAINDEC_BNE_EN adds BNE (op 000101) through the BRANCH state with inverted zero sense.
module mc_maindec (
  input  logic          clk,
  input  logic          reset,
  mc_maindec_if.master  bus
);
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_MAINDEC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       pcwrite;
  logic       branch;
  logic       taken;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Encodings 12-15 fall through the default and recover to FETCH.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
`ifdef MC_MAINDEC_BNE_EN
          OP_BNE:       state_nxt = S_BRANCH;
`endif
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:  state_nxt = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_nxt = S_MEMWB;
      S_EXECUTE: state_nxt = S_ALUWB;
      S_ADDIEX:  state_nxt = S_ADDIWB;
      default:   state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    bus.memwrite = 1'b0;
    bus.irwrite  = 1'b0;
    bus.regwrite = 1'b0;
    bus.iord     = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    bus.aluop    = 2'b00;
    case (state)
      S_FETCH: begin
        bus.irwrite = 1'b1;
        pcwrite     = 1'b1;
        bus.alusrcb = 2'b01;
      end
      S_DECODE:  bus.alusrcb = 2'b11;
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD:   bus.iord = 1'b1;
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b01;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_ADDIWB:  bus.regwrite = 1'b1;
      S_JUMP: begin
        pcwrite   = 1'b1;
        bus.pcsrc = 2'b10;
      end
      default: ;
    endcase
  end

  // op is stable through BRANCH, so it selects the zero sense directly.
`ifdef MC_MAINDEC_BNE_EN
  assign taken = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
`else
  assign taken = bus.zero;
`endif

  assign bus.pcen    = pcwrite | (branch & taken);
  assign bus.state_o = state;
endmodule

// File: tb/tb_mc_maindec.sv
// Randomized + directed bench for mc_maindec against an instruction-level reference model.
module tb_mc_maindec;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  mc_maindec_if bus ();

  mc_maindec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic bne_enabled();
`ifdef MC_MAINDEC_BNE_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Cycles each instruction occupies, straight from the latency table.
  function automatic int instr_len(input logic [5:0] o);
    case (o)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return 4;
      6'b001000: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      6'b000101: return bne_enabled() ? 3 : 2;
      default:   return 2;
    endcase
  endfunction

  function automatic int instr_state(input logic [5:0] o, input int k);
    int s[5];
    s = '{0, 1, 0, 0, 0};
    case (o)
      6'b100011: s = '{0, 1, 2, 3, 4};
      6'b101011: s = '{0, 1, 2, 5, 0};
      6'b000000: s = '{0, 1, 6, 7, 0};
      6'b001000: s = '{0, 1, 9, 10, 0};
      6'b000100: s = '{0, 1, 8, 0, 0};
      6'b000010: s = '{0, 1, 11, 0, 0};
      6'b000101: if (bne_enabled()) s = '{0, 1, 8, 0, 0};
      default: ;
    endcase
    return s[k];
  endfunction

  function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] o, input logic z);
    ctrl_t c;
    c = '0;
    case (st)
      0:  begin c.irwrite = 1; c.pcen = 1; c.alusrcb = 2'b01; end
      1:  c.alusrcb = 2'b11;
      2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      3:  c.iord = 1;
      4:  begin c.regwrite = 1; c.memtoreg = 1; end
      5:  begin c.iord = 1; c.memwrite = 1; end
      6:  begin c.alusrca = 1; c.aluop = 2'b10; end
      7:  begin c.regwrite = 1; c.regdst = 1; end
      8:  begin
        c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01;
        c.pcen = (bne_enabled() && o == 6'b000101) ? ~z : z;
      end
      9:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      10: c.regwrite = 1;
      11: begin c.pcen = 1; c.pcsrc = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctrl_t dut_ctrl();
    ctrl_t c;
    c = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord, bus.regdst,
         bus.memtoreg, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop};
    return c;
  endfunction

  // Runs one instruction from FETCH; zmode 0/1 forces zero, 2 randomizes it each cycle.
  task automatic run_instr(input logic [5:0] o, input int zmode);
    int    st;
    logic  z;
    ctrl_t c;
    logic  pcen_before;
    bus.op = o;
    for (int k = 0; k < instr_len(o); k++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      bus.zero = z;
      #1;
      st = instr_state(o, k);
      c  = dut_ctrl();
      check($sformatf("state op=%b k=%0d", o, k), 32'(bus.state_o), 32'(st));
      check($sformatf("ctrl op=%b st=%0d", o, st), 32'(c), 32'(exp_ctrl(st, o, z)));
      check("excl", 32'(($countones({bus.memwrite, bus.regwrite, bus.irwrite}) > 1)), 32'd0);
      if (st != 8) begin
        pcen_before = bus.pcen;
        bus.zero = ~z;
        #1;
        check($sformatf("pcen_zero_indep st=%0d", st), 32'(bus.pcen), 32'(pcen_before));
      end
      @(negedge clk);
    end
  endtask

  logic [5:0] op_pool [9];

  initial begin
    op_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                6'b000010, 6'b000101, 6'b111111, 6'b010101};
    reset    = 1'b1;
    bus.op   = 6'b000000;
    bus.zero = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(bus.state_o), 32'd0);
    check("reset_ctrl", 32'(dut_ctrl()), 32'(exp_ctrl(0, 6'b000000, 1'b0)));
    reset = 1'b0;

    // Directed coverage: each opcode class, both BEQ outcomes, BNE-not-taken case.
    run_instr(6'b100011, 2);
    run_instr(6'b101011, 2);
    run_instr(6'b000100, 1);
    run_instr(6'b000100, 0);
    run_instr(6'b000000, 2);
    run_instr(6'b111111, 2);
    run_instr(6'b000101, 0);
    run_instr(6'b000101, 1);
    run_instr(6'b001000, 2);
    run_instr(6'b000010, 2);

    // Reset asserted mid-LW while in MEMRD.
    bus.op = 6'b100011;
    bus.zero = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_state", 32'(bus.state_o), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_state", 32'(bus.state_o), 32'd0);
    check("midreset_irwrite", 32'(bus.irwrite), 32'd1);
    check("midreset_pcen", 32'(bus.pcen), 32'd1);
    @(negedge clk);
    check("held_reset_state", 32'(bus.state_o), 32'd0);
    reset = 1'b0;
    run_instr(6'b100011, 2);

    for (int i = 0; i < 300; i++) begin
      logic [5:0] o;
      if ($urandom_range(0, 3) == 0) o = 6'($urandom);
      else                           o = op_pool[$urandom_range(0, 8)];
      run_instr(o, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mc_maindec.md
MC_MAINDEC -- requirements
Module: mc_maindec

Interface
REQ-001 The block SHALL have no parameters; all behaviour is fixed, except the one macro-selected feature in Configuration.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  opcode field from the instruction register; held stable by the datapath for the whole instruction.
- zero  input  1  ALU zero flag, valid in BRANCH state.
- pcen  output  1  PC register enable.
- memwrite  output  1  data memory write enable.
- irwrite  output  1  instruction register load enable.
- regwrite  output  1  register file write enable.
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- regdst  output  1  write register select: 0 = rt, 1 = rd.
- memtoreg  output  1  write-back data select: 0 = ALUOut, 1 = Data register.
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B select: 00 = reg B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- pcsrc  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- aluop  output  2  class code to the ALU decoder: 00 = add, 01 = sub, 10 = use funct.
- state_o  output  4  current state encoding, for debug and bench only.

Function
REQ-003 The controller SHALL be a Moore FSM with a 4-bit state register; only pcen depends combinationally on zero.
REQ-004 The state encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-005 Unused encodings 12-15 SHALL go to FETCH on the next edge, with all outputs 0.
REQ-006 Opcode values SHALL be: LW=100011, SW=101011, RTYPE=000000, BEQ=000100, ADDI=001000, J=000010.
REQ-007 State transitions SHALL be:
- FETCH -> DECODE.
- DECODE -> MEMADR for LW or SW; -> EXECUTE for RTYPE; -> BRANCH for BEQ; -> ADDIEX for ADDI; -> JUMP for J.
- MEMADR -> MEMRD for LW; -> MEMWR for SW.
- MEMRD -> MEMWB.
- EXECUTE -> ALUWB.
- ADDIEX -> ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP -> FETCH.
REQ-008 Any opcode not listed in REQ-006 (or in Configuration) SHALL make DECODE go to FETCH, so the instruction executes as a no-op.
REQ-009 Per-state outputs SHALL be as listed below; any output not listed is 0:
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00, pcsrc=00, iord=0.
- DECODE: alusrcb=11, aluop=00.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: regwrite=1, memtoreg=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regwrite=1, regdst=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JUMP: pcwrite=1, pcsrc=10.
REQ-010 pcen SHALL equal pcwrite | (branch & taken); taken = zero for BEQ.
REQ-011 Instruction latency in cycles SHALL be: LW 5; SW 4; RTYPE 4; ADDI 4; BEQ 3; J 3; unknown opcode 2.
REQ-012 memwrite, regwrite and irwrite SHALL never be asserted in the same cycle.

Reset
REQ-013 When reset is 1 at a rising edge, the state SHALL become FETCH, regardless of the current state, including mid-instruction.
REQ-014 While in the post-reset FETCH state, outputs SHALL be the FETCH values from REQ-009, giving pcen=1.
REQ-015 On the cycle after reset deasserts, the state SHALL advance to DECODE.

Configuration
REQ-016 Macro MC_MAINDEC_BNE_EN defined SHALL add BNE (op=000101): DECODE -> BRANCH, with taken = ~zero in BRANCH, latency 3.
REQ-017 With MC_MAINDEC_BNE_EN undefined, op=000101 SHALL be treated as an unknown opcode per REQ-008.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset, then op=100011 held -> state_o sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
- op=101011 -> state_o sequence 0,1,2,5,0; memwrite=1 only in state 5, with iord=1.
- op=000100 with zero=1 in BRANCH -> pcen=1 and pcsrc=01; repeat with zero=0 -> pcen=0.
- op=000000 -> aluop=10 in state 6; state 7 gives regdst=1, regwrite=1.
- op=111111 -> state_o sequence 0,1,0; op=000101 with BNE_EN defined and zero=0 -> state 8 with pcen=1.
- Assert reset while in state 3 -> state_o=0 on the next edge with irwrite=1; zero toggled outside BRANCH -> pcen unchanged.
